program_loader: RTL and testbench

Upstream loader for the instruction memory. It receives a framed program image as a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. It writes each word into instruction memory at consecutive addresses from 0, checks a trailing XOR checksum, then raises `fin_file` so the control unit can begin fetching. It replaces the file-read path for loading programs into the GPP.

---
 rtl/program_loader_if.sv | 26 ++
 rtl/program_loader.sv | 197 +++++++++++++++++++
 tb/tb_program_loader.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream handshake and instruction-memory write bus for the program loader.
// The loader sits on the slave side; the byte source / memory sink is the master.
interface program_loader_if #(
    parameter int ADDR_W = 9
);
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic [ADDR_W:0]   word_count;
    logic              fin_file;
    logic              error;

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, wr_en, wr_addr, wr_data, word_count, fin_file, error
    );

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, wr_en, wr_addr, wr_data, word_count, fin_file, error
    );
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed byte frame into instruction memory as
// big-endian 16-bit words starting at address 0, then flags completion or error.
module program_loader #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic            clk,
    input  logic            rst,
    program_loader_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_HI  = 3'd1,
        LEN_LO  = 3'd2,
        DATA_HI = 3'd3,
        DATA_LO = 3'd4,
        CHECK   = 3'd5,
        DONE    = 3'd6,
        ERR     = 3'd7
    } state_t;

    localparam logic [15:0]     DEPTH_W = 16'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t            state_r;
    state_t            next_state_s;
    logic              restart_s;
    logic              accept_s;
    logic [15:0]       len_s;
    logic              len_bad_s;
    logic              last_word_s;
    logic              loading_s;

    logic              byte_ready_r;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [15:0]       wr_data_r;
    logic [ADDR_W:0]   word_count_r;
    logic              fin_file_r;
    logic              error_r;
    logic [7:0]        acc_r;
    logic [7:0]        len_hi_r;
    logic [7:0]        hi_r;
    logic [ADDR_W:0]   len_r;

    assign accept_s    = bus.byte_valid & byte_ready_r;
    assign len_s       = {len_hi_r, bus.byte_in};
    assign len_bad_s   = (len_s == 16'd0) || (len_s > DEPTH_W);
    // word_count has already caught up with the previous write when DATA_LO is accepted
    assign last_word_s = (word_count_r == (len_r - CNT_ONE));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic and restart decode
    always_comb begin
        next_state_s = state_r;
        restart_s    = 1'b0;
        case (state_r)
            IDLE, DONE, ERR: begin
                if (bus.start) begin
                    next_state_s = LEN_HI;
                    restart_s    = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end
            LEN_HI: begin
                if (accept_s) begin
                    next_state_s = LEN_LO;
                end else begin
                    next_state_s = state_r;
                end
            end
            LEN_LO: begin
                if (accept_s) begin
                    if (len_bad_s) begin
                        next_state_s = ERR;
                    end else begin
                        next_state_s = DATA_HI;
                    end
                end else begin
                    next_state_s = state_r;
                end
            end
            DATA_HI: begin
                if (accept_s) begin
                    next_state_s = DATA_LO;
                end else begin
                    next_state_s = state_r;
                end
            end
            DATA_LO: begin
                if (accept_s) begin
                    if (last_word_s) begin
                        next_state_s = CHECK;
                    end else begin
                        next_state_s = DATA_HI;
                    end
                end else begin
                    next_state_s = state_r;
                end
            end
            CHECK: begin
                if (accept_s) begin
                    if (bus.byte_in == acc_r) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = ERR;
                    end
                end else begin
                    next_state_s = state_r;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // byte_ready is registered from the next state so it depends on state alone
    always_comb begin
        loading_s = 1'b0;
        case (next_state_s)
            LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK: loading_s = 1'b1;
            default:                                 loading_s = 1'b0;
        endcase
    end

    // Datapath: length capture, checksum accumulation, word assembly and write strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_ready_r <= 1'b0;
            wr_en_r      <= 1'b0;
            wr_addr_r    <= {ADDR_W{1'b0}};
            wr_data_r    <= 16'h0000;
            word_count_r <= {(ADDR_W+1){1'b0}};
            fin_file_r   <= 1'b0;
            error_r      <= 1'b0;
            acc_r        <= 8'h00;
            len_hi_r     <= 8'h00;
            hi_r         <= 8'h00;
            len_r        <= {(ADDR_W+1){1'b0}};
        end else begin
            byte_ready_r <= loading_s;
            fin_file_r   <= (next_state_s == DONE);
            error_r      <= (next_state_s == ERR);
            wr_en_r      <= 1'b0;
            if (restart_s) begin
                acc_r        <= 8'h00;
                word_count_r <= {(ADDR_W+1){1'b0}};
                wr_addr_r    <= {ADDR_W{1'b0}};
            end else begin
                if (accept_s && (state_r != CHECK)) begin
                    acc_r <= xor_fold(acc_r, bus.byte_in);
                end
                if (wr_en_r && (word_count_r < len_r)) begin
                    word_count_r <= word_count_r + CNT_ONE;
                end
                if (accept_s) begin
                    case (state_r)
                        LEN_HI:  len_hi_r <= bus.byte_in;
                        LEN_LO:  len_r    <= len_s[ADDR_W:0];
                        DATA_HI: hi_r     <= bus.byte_in;
                        DATA_LO: begin
                            wr_en_r   <= 1'b1;
                            wr_addr_r <= word_count_r[ADDR_W-1:0];
                            wr_data_r <= {hi_r, bus.byte_in};
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    assign bus.byte_ready = byte_ready_r;
    assign bus.wr_en      = wr_en_r;
    assign bus.wr_addr    = wr_addr_r;
    assign bus.wr_data    = wr_data_r;
    assign bus.word_count = word_count_r;
    assign bus.fin_file   = fin_file_r;
    assign bus.error      = error_r;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table of frames, hand-written reset/restart sequences,
// and random frames checked against a frame-level reference model.
module tb_program_loader;

    logic clk = 1'b0;
    logic rst;

    program_loader_if #(.ADDR_W(9)) bus ();

    program_loader #(.DEPTH(512), .ADDR_W(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] len;
        bit          fixed;
        bit          corrupt;
        int          max_gap;
        bit          mid_start;
        bit          exp_fin;
        bit          exp_err;
        int          exp_wc;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  frame[$];
    logic [24:0] exp_w[$];
    logic [24:0] got_w[$];
    int          exp_consumed;
    bit          exp_fin;
    bit          exp_err;
    logic        got_fin;
    logic        got_err;
    logic [9:0]  got_wc;
    vec_t        tbl[$];

    // Every write strobe seen on the memory bus
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) got_w.push_back({bus.wr_addr, bus.wr_data});
    end

    initial begin
        #3ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(string n, logic [15:0] l, bit f, bit c, int g, bit m,
                                bit ef, bit ee, int wc);
        vec_t v;
        v.name = n; v.len = l; v.fixed = f; v.corrupt = c; v.max_gap = g;
        v.mid_start = m; v.exp_fin = ef; v.exp_err = ee; v.exp_wc = wc;
        return v;
    endfunction

    // Frame bytes: length, payload (1234/ABCD when fixed), XOR checksum optionally spoiled
    task automatic build(input logic [15:0] len, input bit fixed, input bit corrupt);
        logic [7:0]  x;
        logic [15:0] w;
        int          n;
        frame.delete();
        frame.push_back(len[15:8]);
        frame.push_back(len[7:0]);
        n = int'(len);
        if (n >= 1 && n <= 512) begin
            for (int i = 0; i < n; i++) begin
                if (fixed) w = (i == 0) ? 16'h1234 : 16'hABCD;
                else       w = 16'($urandom);
                frame.push_back(w[15:8]);
                frame.push_back(w[7:0]);
            end
        end
        x = 8'h00;
        foreach (frame[j]) x = x ^ frame[j];
        if (corrupt) x = x ^ 8'h01;
        frame.push_back(x);
    endtask

    // Reference: what a correct loader does with this frame
    task automatic model_frame();
        int         n;
        logic [7:0] x;
        exp_w.delete();
        n = int'({frame[0], frame[1]});
        if (n == 0 || n > 512) begin
            exp_consumed = 2; exp_fin = 1'b0; exp_err = 1'b1;
        end else begin
            x = 8'h00;
            for (int j = 0; j < 2 + 2 * n; j++) x = x ^ frame[j];
            for (int i = 0; i < n; i++)
                exp_w.push_back({9'(i), frame[2 + 2 * i], frame[3 + 2 * i]});
            exp_consumed = 2 * n + 3;
            exp_fin = (frame[2 + 2 * n] == x);
            exp_err = !exp_fin;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (bus.byte_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (bus.byte_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=%0h required=1", bus.byte_ready);
        end else begin
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_frame(input string name, input int max_gap, input bit mid_start);
        model_frame();
        got_w.delete();
        pulse_start();
        chk({name, "_ready_after_start"}, 64'(bus.byte_ready), 64'd1);
        chk({name, "_flags_drop"}, 64'({bus.fin_file, bus.error}), 64'd0);
        for (int i = 0; i < exp_consumed; i++) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
            if (mid_start && i == 2) bus.start = 1'b1;
            if (mid_start && i == 5) bus.start = 1'b0;
            send_byte(frame[i]);
        end
        got_fin = bus.fin_file;
        got_err = bus.error;
        chk({name, "_ready_low_at_end"}, 64'(bus.byte_ready), 64'd0);
        @(negedge clk);
        got_wc = bus.word_count;
        chk({name, "_write_count"}, 64'(got_w.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
            chk({name, "_write"}, 64'(got_w[i]), 64'(exp_w[i]));
    endtask

    initial begin
        int kind;
        int n;
        bit cor;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.byte_in = 8'h00;
        bus.byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            64'({bus.byte_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.word_count,
                 bus.fin_file, bus.error}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", 64'({bus.byte_ready, bus.fin_file, bus.error}), 64'd0);

        tbl.push_back(mk("t1",      16'd2,      1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 2));
        tbl.push_back(mk("badck",   16'd2,      1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 2));
        tbl.push_back(mk("recover", 16'd2,      1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 2));
        tbl.push_back(mk("len0",    16'h0000,   1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 0));
        tbl.push_back(mk("len513",  16'h0201,   1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 0));
        tbl.push_back(mk("gaps",    16'd2,      1'b1, 1'b0, 5, 1'b0, 1'b1, 1'b0, 2));
        tbl.push_back(mk("midstart",16'd2,      1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 2));
        tbl.push_back(mk("n512",    16'd512,    1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 512));
        tbl.push_back(mk("n1",      16'd1,      1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1));
        tbl.push_back(mk("lenffff", 16'hFFFF,   1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 0));

        foreach (tbl[i]) begin
            build(tbl[i].len, tbl[i].fixed, tbl[i].corrupt);
            run_frame(tbl[i].name, tbl[i].max_gap, tbl[i].mid_start);
            chk({tbl[i].name, "_fin"},   64'(got_fin), 64'(tbl[i].exp_fin));
            chk({tbl[i].name, "_err"},   64'(got_err), 64'(tbl[i].exp_err));
            chk({tbl[i].name, "_count"}, 64'(got_wc),  64'(tbl[i].exp_wc));
        end

        // Reset in the middle of a frame, right as the first write is on the bus
        build(16'd2, 1'b1, 1'b0);
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(frame[i]);
        chk("mid_write_strobe", 64'({bus.wr_en, bus.wr_addr, bus.wr_data}),
            64'({1'b1, 9'd0, 16'h1234}));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_frame",
            64'({bus.byte_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.word_count,
                 bus.fin_file, bus.error}), 64'd0);
        rst = 1'b0;
        run_frame("after_rst", 0, 1'b0);
        chk("after_rst_fin", 64'({got_fin, got_err}), 64'b10);
        chk("after_rst_count", 64'(got_wc), 64'd2);

        // Random frames against the reference model
        for (int r = 0; r < 25; r++) begin
            kind = int'($urandom_range(0, 9));
            cor  = ($urandom_range(0, 3) == 0);
            if (kind == 0)      build(16'h0000, 1'b0, cor);
            else if (kind == 1) build(16'(513 + $urandom_range(0, 2000)), 1'b0, cor);
            else begin
                n = int'($urandom_range(1, 24));
                build(16'(n), 1'b0, cor);
            end
            run_frame("rand", int'($urandom_range(0, 3)), 1'b0);
            chk("rand_fin", 64'(got_fin), 64'(exp_fin));
            chk("rand_err", 64'(got_err), 64'(exp_err));
            chk("rand_count", 64'(got_wc), 64'(exp_w.size()));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
